// File: rtl/csr_trap_sequencer.sv
// Sequences machine-mode CSR updates on trap entry and MRET, and forwards the
// pipeline CSR port to the CSR file while idle.
module csr_trap_sequencer #(
  parameter logic [11:0] ADDR_MSTATUS = 12'h300,
  parameter logic [11:0] ADDR_MTVEC   = 12'h305,
  parameter logic [11:0] ADDR_MEPC    = 12'h341,
  parameter logic [11:0] ADDR_MCAUSE  = 12'h342,
  parameter logic [11:0] ADDR_MTVAL   = 12'h343
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_val,
  input  logic        mret_req,
  output logic        req_ack,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        pipe_wb_csr,
  input  logic [11:0] pipe_write_addr,
  input  logic [31:0] pipe_in_data,
  input  logic [11:0] pipe_addr,
  output logic        csr_wb,
  output logic [11:0] csr_write_addr,
  output logic [31:0] csr_in_data,
  output logic [11:0] csr_addr,
  input  logic [31:0] csr_out_data
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [3:0] {
    IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_VEC, M_RD, M_WR, M_EPC
  } state_t;

  state_t            state, state_n;
  logic              req_ack_n, busy_n, redirect_valid_n;
  logic [XLEN-1:0]   redirect_pc_n;
  logic              is_trap, is_trap_n;
  logic [XLEN-1:0]   cause_q, cause_n, pc_q, pc_n, val_q, val_n;
  logic [XLEN-1:0]   mstatus_q, mstatus_n;
  logic [XLEN-1:0]   trap_status, mret_status, vec_base, vec_pc;

  // MPIE<=MIE, MIE<=0, MPP<=M on entry; MIE<=MPIE, MPIE<=1, MPP<=U on return
  assign trap_status = {mstatus_q[31:13], 2'b11, mstatus_q[10:8], mstatus_q[3],
                        mstatus_q[6:4], 1'b0, mstatus_q[2:0]};
  assign mret_status = {mstatus_q[31:13], 2'b00, mstatus_q[10:8], 1'b1,
                        mstatus_q[6:4], mstatus_q[7], mstatus_q[2:0]};

  // Vectored mode offsets only interrupts, by 4*cause
  assign vec_base = csr_out_data & ALIGN_MASK;
  assign vec_pc   = (csr_out_data[1:0] == 2'b01 && cause_q[31])
                  ? XLEN'(vec_base + XLEN'({cause_q[30:0], 2'b00}))
                  : vec_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_ack        <= 1'b0;
      busy           <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      is_trap        <= 1'b0;
      cause_q        <= '0;
      pc_q           <= '0;
      val_q          <= '0;
      mstatus_q      <= '0;
    end else begin
      state          <= state_n;
      req_ack        <= req_ack_n;
      busy           <= busy_n;
      redirect_valid <= redirect_valid_n;
      redirect_pc    <= redirect_pc_n;
      is_trap        <= is_trap_n;
      cause_q        <= cause_n;
      pc_q           <= pc_n;
      val_q          <= val_n;
      mstatus_q      <= mstatus_n;
    end
  end

  // Next state; req_ack doubles as the "accepted, start next cycle" marker
  always_comb begin
    state_n          = state;
    req_ack_n        = 1'b0;
    redirect_valid_n = 1'b0;
    redirect_pc_n    = redirect_pc;
    is_trap_n        = is_trap;
    cause_n          = cause_q;
    pc_n             = pc_q;
    val_n            = val_q;
    mstatus_n        = mstatus_q;
    case (state)
      IDLE: begin
        if (req_ack) begin
          state_n = is_trap ? T_EPC : M_RD;
        end else if (trap_req || mret_req) begin
          req_ack_n = 1'b1;
          is_trap_n = trap_req;
          cause_n   = trap_cause;
          pc_n      = trap_pc;
          val_n     = trap_val;
        end
      end
      T_EPC: begin
        mstatus_n = csr_out_data;
        state_n   = T_CAUSE;
      end
      T_CAUSE:  state_n = T_TVAL;
      T_TVAL:   state_n = T_STATUS;
      T_STATUS: state_n = T_VEC;
      T_VEC: begin
        state_n          = IDLE;
        redirect_valid_n = 1'b1;
        redirect_pc_n    = vec_pc;
      end
      M_RD: begin
        mstatus_n = csr_out_data;
        state_n   = M_WR;
      end
      M_WR: state_n = M_EPC;
      M_EPC: begin
        state_n          = IDLE;
        redirect_valid_n = 1'b1;
        redirect_pc_n    = csr_out_data & ALIGN_MASK;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  // CSR file port: pass-through when idle, sequencer-owned otherwise
  always_comb begin
    csr_wb         = 1'b0;
    csr_write_addr = ADDR_MTVAL;
    csr_in_data    = '0;
    csr_addr       = ADDR_MTVEC;
    case (state)
      IDLE: begin
        csr_wb         = pipe_wb_csr & ~trap_req;
        csr_write_addr = pipe_write_addr;
        csr_in_data    = pipe_in_data;
        csr_addr       = pipe_addr;
      end
      T_EPC: begin
        csr_wb         = 1'b1;
        csr_write_addr = ADDR_MEPC;
        csr_in_data    = pc_q & ALIGN_MASK;
        csr_addr       = ADDR_MSTATUS;
      end
      T_CAUSE: begin
        csr_wb         = 1'b1;
        csr_write_addr = ADDR_MCAUSE;
        csr_in_data    = cause_q;
      end
      T_TVAL: begin
        csr_wb         = 1'b1;
        csr_write_addr = ADDR_MTVAL;
        csr_in_data    = val_q;
      end
      T_STATUS: begin
        csr_wb         = 1'b1;
        csr_write_addr = ADDR_MSTATUS;
        csr_in_data    = trap_status;
      end
      T_VEC: csr_addr = ADDR_MTVEC;
      M_RD:  csr_addr = ADDR_MSTATUS;
      M_WR: begin
        csr_wb         = 1'b1;
        csr_write_addr = ADDR_MSTATUS;
        csr_in_data    = mret_status;
      end
      M_EPC: csr_addr = ADDR_MEPC;
      default: csr_wb = 1'b0;
    endcase
    if (!rst_n) csr_wb = 1'b0;
  end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Bench for csr_trap_sequencer: CSR file model, transaction-level reference
// model with per-cycle compare, and directed scenarios with literal expectations.
module tb_csr_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trap_req = 1'b0, mret_req = 1'b0;
  logic [31:0] trap_cause = '0, trap_pc = '0, trap_val = '0;
  logic        req_ack, busy, redirect_valid;
  logic [31:0] redirect_pc;
  logic        pipe_wb_csr = 1'b0;
  logic [11:0] pipe_write_addr = '0, pipe_addr = '0;
  logic [31:0] pipe_in_data = '0;
  logic        csr_wb;
  logic [11:0] csr_write_addr, csr_addr;
  logic [31:0] csr_in_data, csr_out_data;

  always #5 clk = ~clk;

  csr_trap_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_val(trap_val),
    .mret_req(mret_req), .req_ack(req_ack), .busy(busy),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pipe_wb_csr(pipe_wb_csr), .pipe_write_addr(pipe_write_addr),
    .pipe_in_data(pipe_in_data), .pipe_addr(pipe_addr),
    .csr_wb(csr_wb), .csr_write_addr(csr_write_addr), .csr_in_data(csr_in_data),
    .csr_addr(csr_addr), .csr_out_data(csr_out_data)
  );

  // CSR register file: combinational read, write on the clock edge
  bit [31:0] mem [0:4095];
  assign csr_out_data = mem[csr_addr];
  always @(posedge clk) if (csr_wb) mem[csr_write_addr] <= csr_in_data;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: k counts cycles since the accepting edge (1 = ack cycle,
  // len+1 = redirect cycle); architectural effects applied at acceptance.
  bit [31:0]   ref_csr [0:4095];
  int          k = 0;
  int          len = 6;
  logic [31:0] exp_pc = '0, next_pc = '0;
  logic [11:0] pend_addr [4];
  logic [31:0] pend_data [4];
  int          n_pend = 0;

  always @(posedge clk or negedge rst_n) begin : model_p
    logic [31:0] m, tv;
    if (!rst_n) begin
      k = 0; exp_pc = '0; n_pend = 0;
      for (int i = 0; i < 4096; i++) ref_csr[i] = mem[i];
    end else begin
      if ((k == 0 || k == 1 || k == len + 1) && pipe_wb_csr && !trap_req)
        ref_csr[pipe_write_addr] = pipe_in_data;
      if ((k == 0 || k == len + 1) && (trap_req || mret_req)) begin
        k = 1;
        m = ref_csr[12'h300];
        if (trap_req) begin
          len = 6;
          ref_csr[12'h341] = trap_pc & ~32'd3;
          ref_csr[12'h342] = trap_cause;
          ref_csr[12'h343] = trap_val;
          ref_csr[12'h300] = (m & ~32'h0000_1888) | 32'h0000_1800 | (m[3] ? 32'h80 : 32'h0);
          tv = ref_csr[12'h305];
          next_pc = tv & ~32'd3;
          if (tv[1:0] == 2'b01 && trap_cause[31])
            next_pc = next_pc + (trap_cause & 32'h7FFF_FFFF) * 4;
          pend_addr[0] = 12'h341; pend_data[0] = ref_csr[12'h341];
          pend_addr[1] = 12'h342; pend_data[1] = ref_csr[12'h342];
          pend_addr[2] = 12'h343; pend_data[2] = ref_csr[12'h343];
          pend_addr[3] = 12'h300; pend_data[3] = ref_csr[12'h300];
          n_pend = 4;
        end else begin
          len = 4;
          ref_csr[12'h300] = (m & ~32'h0000_1888) | 32'h80 | (m[7] ? 32'h8 : 32'h0);
          next_pc = ref_csr[12'h341] & ~32'd3;
          pend_addr[0] = 12'h300; pend_data[0] = ref_csr[12'h300];
          n_pend = 1;
        end
      end else if (k >= 1 && k <= len) begin
        k++;
        if (k == len + 1) exp_pc = next_pc;
      end else begin
        k = 0;
      end
    end
  end

  // Per-cycle compare of registered outputs against the model
  always @(posedge clk) begin
    #3;
    check("req_ack", 32'(req_ack), 32'(k == 1));
    check("busy", 32'(busy), 32'(k >= 2 && k <= len));
    check("redirect_valid", 32'(redirect_valid), 32'(k == len + 1));
    check("redirect_pc", redirect_pc, exp_pc);
    if (k == len + 1)
      for (int i = 0; i < n_pend; i++) check("csr_contents", mem[pend_addr[i]], pend_data[i]);
  end

  task automatic pipe_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pipe_wb_csr = 1'b1; pipe_write_addr = a; pipe_in_data = d;
    @(negedge clk);
    pipe_wb_csr = 1'b0;
  endtask

  // Issue a request; c counts edges from E0 (c=1 is the cycle after E0)
  task automatic do_req(input bit t, input bit m, input bit pw0, input int pw_c,
                        input int rst_c, output int ack_c, output int rv_c,
                        output logic [31:0] pc);
    ack_c = -1; rv_c = -1; pc = '0;
    @(negedge clk);
    trap_req = t; mret_req = m;
    if (pw0) begin
      pipe_wb_csr = 1'b1; pipe_write_addr = 12'h340; pipe_in_data = 32'h1234;
    end
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (req_ack && ack_c < 0) begin
        ack_c = c; trap_req = 1'b0; mret_req = 1'b0; pipe_wb_csr = 1'b0;
      end
      if (c == pw_c) begin
        pipe_wb_csr = 1'b1; pipe_write_addr = 12'h340; pipe_in_data = 32'hAA;
        check("busy_during_pipe_write", 32'(busy), 32'd1);
      end else if (c == pw_c + 1) begin
        pipe_wb_csr = 1'b0;
      end
      if (c == rst_c) begin
        rst_n = 1'b0;
        pipe_wb_csr = 1'b1; pipe_write_addr = 12'h340; pipe_in_data = 32'h77;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_csr_wb", 32'(csr_wb), 32'd0);
        check("reset_redirect_valid", 32'(redirect_valid), 32'd0);
        pipe_wb_csr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      if (redirect_valid) begin
        rv_c = c; pc = redirect_pc;
        break;
      end
    end
    trap_req = 1'b0; mret_req = 1'b0; pipe_wb_csr = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int ack_c, rv_c, seen;
    logic [31:0] pc;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ack", 32'(req_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_csr_wb", 32'(csr_wb), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Direct-mode trap
    pipe_write(12'h305, 32'h0000_1000);
    pipe_write(12'h300, 32'h0000_0008);
    trap_cause = 32'd2; trap_pc = 32'h0000_0204; trap_val = 32'hDEAD_BEEF;
    do_req(1, 0, 0, 0, 0, ack_c, rv_c, pc);
    check("t1_ack_cycle", 32'(ack_c), 32'd1);
    check("t1_redirect_edge", 32'(rv_c - 1), 32'd6);
    check("t1_redirect_pc", pc, 32'h0000_1000);
    check("t1_mepc", mem[12'h341], 32'h0000_0204);
    check("t1_mcause", mem[12'h342], 32'd2);
    check("t1_mtval", mem[12'h343], 32'hDEAD_BEEF);
    check("t1_mstatus", mem[12'h300], 32'h0000_1880);

    // Vectored-mode interrupt
    pipe_write(12'h305, 32'h0000_1001);
    trap_cause = 32'h8000_0007; trap_pc = 32'h0000_0302; trap_val = 32'h0;
    do_req(1, 0, 0, 0, 0, ack_c, rv_c, pc);
    check("t2_redirect_pc", pc, 32'h0000_101C);
    check("t2_mepc_aligned", mem[12'h341], 32'h0000_0300);
    check("t2_mstatus", mem[12'h300], 32'h0000_1800);

    // MRET
    pipe_write(12'h300, 32'h0000_1880);
    pipe_write(12'h341, 32'h0000_0208);
    do_req(0, 1, 0, 0, 0, ack_c, rv_c, pc);
    check("t3_ack_cycle", 32'(ack_c), 32'd1);
    check("t3_redirect_edge", 32'(rv_c - 1), 32'd4);
    check("t3_redirect_pc", pc, 32'h0000_0208);
    check("t3_mstatus", mem[12'h300], 32'h0000_0088);

    // Trap, MRET and pipeline write together: trap wins, write dropped
    pipe_write(12'h300, 32'h0000_0008);
    trap_cause = 32'd3; trap_pc = 32'h0000_0500; trap_val = 32'h0000_0042;
    do_req(1, 1, 1, 0, 0, ack_c, rv_c, pc);
    check("t4_redirect_edge", 32'(rv_c - 1), 32'd6);
    check("t4_redirect_pc", pc, 32'h0000_1000);
    check("t4_pipe_write_dropped", mem[12'h340], 32'h0);
    check("t4_mstatus", mem[12'h300], 32'h0000_1880);
    check("t4_mepc", mem[12'h341], 32'h0000_0500);

    // Pipeline write in idle lands; the same write during T_CAUSE is ignored
    pipe_write(12'h340, 32'h55);
    check("t5_idle_write", mem[12'h340], 32'h55);
    trap_cause = 32'd4; trap_pc = 32'h0000_0600; trap_val = 32'h1;
    do_req(1, 0, 0, 3, 0, ack_c, rv_c, pc);
    check("t5_busy_write_ignored", mem[12'h340], 32'h55);
    check("t5_redirect_pc", pc, 32'h0000_1000);

    // Reset during T_TVAL aborts; a following trap completes normally
    trap_cause = 32'd6; trap_pc = 32'h0000_0700; trap_val = 32'h2;
    do_req(1, 0, 0, 0, 4, ack_c, rv_c, pc);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      seen += int'(redirect_valid);
    end
    check("t6_no_redirect_after_reset", 32'(seen), 32'd0);
    check("t6_no_write_during_reset", mem[12'h340], 32'h55);
    trap_cause = 32'd5; trap_pc = 32'h0000_0800; trap_val = 32'h3;
    do_req(1, 0, 0, 0, 0, ack_c, rv_c, pc);
    check("t6_redirect_edge", 32'(rv_c - 1), 32'd6);
    check("t6_redirect_pc", pc, 32'h0000_1000);
    check("t6_mcause", mem[12'h342], 32'd5);
    check("t6_mtval", mem[12'h343], 32'd3);

    repeat (3) @(posedge clk);
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
